adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/PARAMS_BN254_d0.sv | 14 +
 rtl/multi_cycle_adder.sv | 35 +++
 rtl/adder_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/PARAMS_BN254_d0.sv
// -----------------------------------------------------------------------------
// PARAMS_BN254_d0
// Shared BN254 field parameters. Provides the field-element container type
// uint_fp_t used by every datapath that carries base-field operands.
// Ports: none (package).
// -----------------------------------------------------------------------------
package PARAMS_BN254_d0;

    // Field elements are carried in a 256-bit container (254-bit modulus).
    localparam int FP_WIDTH = 256;

    typedef logic [FP_WIDTH-1:0] uint_fp_t;

endpackage : PARAMS_BN254_d0

// File: rtl/multi_cycle_adder.sv
// -----------------------------------------------------------------------------
// multi_cycle_adder
// Pipelined plain adder: Z is the truncated sum X + Y, LATENCY rising edges
// after X/Y were presented. No carry out, no modular reduction. Pure datapath,
// therefore no reset.
// Ports:
//   clk  in   clock, rising edge
//   X    in   first operand  (uint_fp_t)
//   Y    in   second operand (uint_fp_t)
//   Z    out  registered sum (uint_fp_t)
// -----------------------------------------------------------------------------
module multi_cycle_adder
    import PARAMS_BN254_d0::*;
#(
    parameter int LATENCY = 3
) (
    input  logic     clk,
    input  uint_fp_t X,
    input  uint_fp_t Y,
    output uint_fp_t Z
);

    uint_fp_t stage_r [LATENCY];

    // Sum computed into the first stage, then delayed through the remaining stages.
    always_ff @(posedge clk) begin
        stage_r[0] <= X + Y;
        for (int k = 1; k < LATENCY; k++) begin
            stage_r[k] <= stage_r[k-1];
        end
    end

    assign Z = stage_r[LATENCY-1];

endmodule : multi_cycle_adder

// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
// Shares one multi_cycle_adder between N_REQ requesters. A round-robin
// arbiter accepts at most one operand pair per cycle, the accepted pair and
// its owner index are registered into the adder inputs, and a valid/tag
// pipeline running beside the adder routes each sum back to its owner
// LATENCY+1 cycles after the accept, in accept order.
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   req_valid  in   [N_REQ]        per-requester operand-pair valid
//   req_ready  out  [N_REQ]        per-requester accept (at most one-hot)
//   req_x      in   uint_fp_t[N]   per-requester first operand
//   req_y      in   uint_fp_t[N]   per-requester second operand
//   res_valid  out  [N_REQ]        one-hot single-cycle result strobe
//   res_z      out  uint_fp_t      shared result bus
//   res_id     out  [clog2(N_REQ)] owner of the current result (0 when idle)
//   busy       out  1              some accepted operation not yet returned
// -----------------------------------------------------------------------------
module adder_arbiter
    import PARAMS_BN254_d0::*;
#(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  uint_fp_t                 req_x [N_REQ],
    input  uint_fp_t                 req_y [N_REQ],
    output logic [N_REQ-1:0]         res_valid,
    output uint_fp_t                 res_z,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic                     busy
);

    localparam int ID_W = $clog2(N_REQ);
    typedef logic [ID_W-1:0] id_t;

    localparam logic [N_REQ-1:0] OH_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam id_t              LAST_ID = id_t'(N_REQ - 1);

    // Arbitration
    id_t              ptr_r;
    id_t              ptr_next_s;
    logic [N_REQ-1:0] grant_s;
    id_t              grant_id_s;
    logic             accept_s;
    id_t              idx_s;
    logic             hit_s;
    logic             found_s;

    // Issue stage (adder inputs)
    logic             iss_vld_r;
    id_t              iss_id_r;
    uint_fp_t         iss_x_r;
    uint_fp_t         iss_y_r;
    logic [N_REQ-1:0] iss_oh_s;

    // Valid/tag pipeline beside the adder; the last stage drives the result outputs
    logic [N_REQ-1:0] oh_pipe_r [LATENCY];
    id_t              id_pipe_r [LATENCY];
    logic             hold_s;
    logic             busy_r;

    // Round-robin search from ptr upward with wrap; first valid requester wins.
    always_comb begin
        grant_s    = '0;
        grant_id_s = '0;
        found_s    = 1'b0;
        idx_s      = '0;
        hit_s      = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s          = id_t'((int'(ptr_r) + k) % N_REQ);
            hit_s          = !found_s && req_valid[idx_s];
            grant_s[idx_s] = hit_s;
            grant_id_s     = hit_s ? idx_s : grant_id_s;
            found_s        = found_s | hit_s;
        end
    end

    // Ready is forced low during reset so nothing is handed over unseen.
    assign req_ready = rstn ? grant_s : '0;
    assign accept_s  = |req_ready;

    // Pointer moves just past the accepted requester; holds when nothing is accepted.
    always_comb begin
        ptr_next_s = ptr_r;
        if (accept_s) begin
            if (grant_id_s == LAST_ID) begin
                ptr_next_s = '0;
            end else begin
                ptr_next_s = grant_id_s + id_t'(1);
            end
        end else begin
            ptr_next_s = ptr_r;
        end
    end

    // Issue stage presented as a one-hot owner vector (zero when empty).
    always_comb begin
        iss_oh_s = '0;
        if (iss_vld_r) begin
            iss_oh_s = OH_ONE << iss_id_r;
        end else begin
            iss_oh_s = '0;
        end
    end

    // Stages that still hold work next cycle: everything except the output stage.
    always_comb begin
        hold_s = 1'b0;
        for (int k = 0; k < LATENCY - 1; k++) begin
            hold_s = hold_s | (|oh_pipe_r[k]);
        end
    end

    // Control state: pointer, issue-valid/owner, valid/tag pipeline and busy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r     <= '0;
            iss_vld_r <= 1'b0;
            iss_id_r  <= '0;
            busy_r    <= 1'b0;
            for (int k = 0; k < LATENCY; k++) begin
                oh_pipe_r[k] <= '0;
                id_pipe_r[k] <= '0;
            end
        end else begin
            ptr_r        <= ptr_next_s;
            iss_vld_r    <= accept_s;
            iss_id_r     <= accept_s ? grant_id_s : '0;
            // iss_id_r is already zero when the issue stage is empty, so
            // res_id reads 0 on idle cycles without further masking.
            oh_pipe_r[0] <= iss_oh_s;
            id_pipe_r[0] <= iss_id_r;
            for (int k = 1; k < LATENCY; k++) begin
                oh_pipe_r[k] <= oh_pipe_r[k-1];
                id_pipe_r[k] <= id_pipe_r[k-1];
            end
            // Registered form of "issue-valid OR any pipeline stage", built
            // from the next-state values of those same bits.
            busy_r       <= accept_s | iss_vld_r | hold_s;
        end
    end

    // Operand capture into the adder inputs; datapath only, not reset.
    always_ff @(posedge clk) begin
        iss_x_r <= req_x[grant_id_s];
        iss_y_r <= req_y[grant_id_s];
    end

    multi_cycle_adder #(
        .LATENCY (LATENCY)
    ) u_adder (
        .clk (clk),
        .X   (iss_x_r),
        .Y   (iss_y_r),
        .Z   (res_z)
    );

    assign res_valid = oh_pipe_r[LATENCY-1];
    assign res_id    = id_pipe_r[LATENCY-1];
    assign busy      = busy_r;

endmodule : adder_arbiter
